mi_executor: RTL and testbench

- Consumer end of the 33-bit micro-instruction word produced by the microprogram decoder ROM.
- Latches each micro-instruction and splits it into fields {ALU[32:29], SH[28:27], Kmx[26], MR[25], MW[24], Bus_B[23:18], Bus_C[17:12], T_word[11:5], Bus_A[4:0]}.
- Sequences the word as timed datapath control strobes, runs the memory read/write handshake, and drives HOLD back to the ROM so the ROM does not advance while an instruction is executing.

---
 rtl/mi_pkg.sv | 37 +++
 rtl/mi_mem_wait.sv | 39 +++
 rtl/mi_executor.sv | 142 ++++++++++++++
 tb/tb_mi_executor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mi_pkg.sv
// Shared definitions for the micro-instruction executor: word field positions,
// special field encodings, T_word bit meanings and the sequencer states.
package mi_pkg;

  localparam int ALU_MSB  = 32;
  localparam int ALU_LSB  = 29;
  localparam int SH_MSB   = 28;
  localparam int SH_LSB   = 27;
  localparam int KMX_BIT  = 26;
  localparam int MR_BIT   = 25;
  localparam int MW_BIT   = 24;
  localparam int BUSB_MSB = 23;
  localparam int BUSB_LSB = 18;
  localparam int BUSC_MSB = 17;
  localparam int BUSC_LSB = 12;
  localparam int T_MSB    = 11;
  localparam int T_LSB    = 5;
  localparam int BUSA_MSB = 4;
  localparam int BUSA_LSB = 0;

  localparam logic [3:0] ALU_NOP  = 4'b1111;
  localparam logic [5:0] BUS_NONE = 6'b100011;

  // Bit indices inside the 7-bit T_word
  localparam int T_PC  = 6;
  localparam int T_CY  = 5;
  localparam int T_Z   = 4;
  localparam int T_REG = 3;

  typedef enum logic [1:0] {
    DECODE = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    WB     = 2'd3
  } state_e;

endpackage

// File: rtl/mi_mem_wait.sv
// Memory wait counter: counts MEM cycles without mem_ready and flags a timeout
// on the cycle in which the count would reach TIMEOUT.
module mi_mem_wait #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic mem_ready,
  output logic done,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (!mem_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done    = en && mem_ready;
  assign timeout = en && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mi_executor.sv
// Micro-instruction executor: latches a ROM word in DECODE and sequences it as
// EXEC / MEM / WB control strobes while holding the ROM.
module mi_executor
  import mi_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [32:0]       micro_instruction,
  input  logic [ADDR_W-1:0] DATA_ADDR,
  input  logic              mem_ready,
  output logic              HOLD,
  output logic [3:0]        alu_op,
  output logic [1:0]        sh_op,
  output logic              kmx,
  output logic [4:0]        bus_a_sel,
  output logic [5:0]        bus_b_sel,
  output logic [5:0]        bus_c_sel,
  output logic              reg_we,
  output logic [2:0]        w_ctl,
  output logic [1:0]        flag_we,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_err
);

  state_e              state_q, state_d;
  logic [32:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mem_err_q, mem_err_d;
  logic                in_mem, mem_done, mem_timeout;

  logic                mr, mw;
  logic [6:0]          t_word;
  logic [5:0]          bus_c;

  assign mr     = instr_q[MR_BIT];
  assign mw     = instr_q[MW_BIT];
  assign t_word = instr_q[T_MSB:T_LSB];
  assign bus_c  = instr_q[BUSC_MSB:BUSC_LSB];
  assign in_mem = (state_q == MEM);

  mi_mem_wait #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (in_mem),
    .mem_ready (mem_ready),
    .done      (mem_done),
    .timeout   (mem_timeout)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    mem_err_d = 1'b0;
    case (state_q)
      DECODE: begin
        instr_d = micro_instruction;
        addr_d  = DATA_ADDR;
        state_d = (micro_instruction[ALU_MSB:ALU_LSB] == ALU_NOP) ? DECODE : EXEC;
      end
      EXEC: state_d = (mr || mw) ? MEM : WB;
      MEM: begin
        if (mem_done) begin
          state_d = WB;
        end else if (mem_timeout) begin
          // Abort: error pulse appears in the following DECODE cycle
          state_d   = DECODE;
          mem_err_d = 1'b1;
        end
      end
      WB:      state_d = DECODE;
      default: state_d = DECODE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DECODE;
      instr_q   <= '0;
      addr_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Outputs decode from registered state so an asynchronous reset clears them at once
  always_comb begin
    HOLD      = (state_q != DECODE);
    alu_op    = '0;
    sh_op     = '0;
    kmx       = 1'b0;
    bus_a_sel = '0;
    bus_b_sel = BUS_NONE;
    bus_c_sel = BUS_NONE;
    reg_we    = 1'b0;
    w_ctl     = '0;
    flag_we   = '0;
    pc_load   = 1'b0;
    pc_target = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_err   = mem_err_q;
    if (state_q != DECODE) begin
      alu_op    = instr_q[ALU_MSB:ALU_LSB];
      sh_op     = instr_q[SH_MSB:SH_LSB];
      kmx       = instr_q[KMX_BIT];
      bus_a_sel = instr_q[BUSA_MSB:BUSA_LSB];
      bus_b_sel = instr_q[BUSB_MSB:BUSB_LSB];
    end
    if (state_q == EXEC && mr && mw) begin
      mem_err = 1'b1;
    end
    if (state_q == MEM) begin
      mem_addr = addr_q;
      mem_rd   = mr;
      mem_wr   = mw && !mr;
    end
    if (state_q == WB) begin
      reg_we    = t_word[T_REG] && (bus_c != BUS_NONE);
      bus_c_sel = bus_c;
      w_ctl     = t_word[2:0];
      flag_we   = {t_word[T_CY], t_word[T_Z]};
      pc_load   = t_word[T_PC];
      pc_target = addr_q;
    end
  end

endmodule

// File: tb/tb_mi_executor.sv
// Scoreboard bench for mi_executor: a ROM model feeds words on the falling edge,
// expected per-instruction results are queued at issue and compared at HOLD fall.
module tb_mi_executor;
  import mi_pkg::*;

  localparam int ADDR_W      = 11;
  localparam int MEM_TIMEOUT = 15;
  localparam logic [32:0] NOP_WORD = {ALU_NOP, 29'd0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [32:0]       micro_instruction = NOP_WORD;
  logic [ADDR_W-1:0] DATA_ADDR = '0;
  logic              mem_ready = 1'b0;
  logic              HOLD, kmx, reg_we, pc_load, mem_rd, mem_wr, mem_err;
  logic [3:0]        alu_op;
  logic [1:0]        sh_op, flag_we;
  logic [4:0]        bus_a_sel;
  logic [5:0]        bus_b_sel, bus_c_sel;
  logic [2:0]        w_ctl;
  logic [ADDR_W-1:0] pc_target, mem_addr;

  mi_executor #(.MEM_TIMEOUT(MEM_TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .micro_instruction(micro_instruction),
    .DATA_ADDR(DATA_ADDR), .mem_ready(mem_ready), .HOLD(HOLD), .alu_op(alu_op),
    .sh_op(sh_op), .kmx(kmx), .bus_a_sel(bus_a_sel), .bus_b_sel(bus_b_sel),
    .bus_c_sel(bus_c_sel), .reg_we(reg_we), .w_ctl(w_ctl), .flag_we(flag_we),
    .pc_load(pc_load), .pc_target(pc_target), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0]       w;
    logic [ADDR_W-1:0] a;
    int                rdy;   // MEM cycle in which mem_ready is seen; 0 = never
  } prog_t;

  typedef struct {
    int                hold;
    int                rd_cycles;
    int                wr_cycles;
    int                strobe_cycles;
    int                err_cycles;
    int                issue;
    logic              tmo;
    logic              reg_we;
    logic [1:0]        flag_we;
    logic [2:0]        w_ctl;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic [ADDR_W-1:0] mem_addr;
    logic [5:0]        bus_c;
    logic [3:0]        alu;
    logic [4:0]        bus_a;
  } exp_t;

  prog_t prog[$];
  exp_t  sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor state
  logic              in_instr = 1'b0;
  int                hold_cnt, rd_cnt, wr_cnt, strobe_cnt, err_cnt, mcnt, cur_rdy;
  logic              alu_unstable;
  logic [3:0]        f_alu;
  logic [4:0]        f_bus_a;
  logic [ADDR_W-1:0] f_maddr;
  logic              l_reg_we, l_pc_load;
  logic [1:0]        l_flag_we;
  logic [2:0]        l_w_ctl;
  logic [ADDR_W-1:0] l_pc_target;
  logic [5:0]        l_bus_c;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [32:0] mk(input logic [3:0] alu, input logic [1:0] sh,
                                     input logic k, input logic mr, input logic mw,
                                     input logic [5:0] bb, input logic [5:0] bc,
                                     input logic [6:0] t, input logic [4:0] ba);
    return {alu, sh, k, mr, mw, bb, bc, t, ba};
  endfunction

  function automatic exp_t mk_exp(input prog_t p, input int issue);
    exp_t e;
    logic [6:0] t;
    logic mr, mw, wb;
    t  = p.w[11:5];
    mr = p.w[25];
    mw = p.w[24];
    e.issue     = issue;
    e.alu       = p.w[32:29];
    e.bus_a     = p.w[4:0];
    e.tmo       = (mr || mw) && (p.rdy == 0);
    e.hold      = !(mr || mw) ? 2 : (e.tmo ? MEM_TIMEOUT + 1 : p.rdy + 2);
    e.rd_cycles = mr ? (e.tmo ? MEM_TIMEOUT : p.rdy) : 0;
    e.wr_cycles = (mw && !mr) ? (e.tmo ? MEM_TIMEOUT : p.rdy) : 0;
    e.err_cycles = (mr && mw) ? 1 : 0;
    e.mem_addr  = (mr || mw) ? p.a : '0;
    wb          = !e.tmo;
    e.reg_we    = wb && t[3] && (p.w[17:12] != BUS_NONE);
    e.flag_we   = wb ? t[5:4] : 2'b00;
    e.w_ctl     = wb ? t[2:0] : 3'b000;
    e.pc_load   = wb && t[6];
    e.pc_target = wb ? p.a : '0;
    e.bus_c     = wb ? p.w[17:12] : BUS_NONE;
    e.strobe_cycles = (e.reg_we || e.flag_we != 0 || e.w_ctl != 0 || e.pc_load) ? 1 : 0;
    return e;
  endfunction

  task automatic check_reset_values();
    check("rst_hold", HOLD, 0);
    check("rst_alu", alu_op, 0);
    check("rst_sh", sh_op, 0);
    check("rst_kmx", kmx, 0);
    check("rst_bus_a", bus_a_sel, 0);
    check("rst_bus_b", bus_b_sel, BUS_NONE);
    check("rst_bus_c", bus_c_sel, BUS_NONE);
    check("rst_strobes", {reg_we, w_ctl, flag_we, pc_load, mem_rd, mem_wr, mem_err}, 0);
    check("rst_addrs", {pc_target, mem_addr}, 0);
  endtask

  task automatic monitor();
    exp_t e;
    logic strobe;
    strobe = reg_we || (flag_we != 0) || (w_ctl != 0) || pc_load;
    if (HOLD) begin
      if (!in_instr) begin
        in_instr = 1'b1;
        hold_cnt = 0; rd_cnt = 0; wr_cnt = 0; strobe_cnt = 0; err_cnt = 0;
        alu_unstable = 1'b0; f_alu = alu_op; f_bus_a = bus_a_sel; f_maddr = '0;
        if (sb.size() == 0) check("sb_start_empty", 1, 0);
        else check("start_latency", cyc, sb[0].issue + 1);
      end
      hold_cnt++;
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
      if ((mem_rd || mem_wr) && f_maddr == '0) f_maddr = mem_addr;
      if (strobe) strobe_cnt++;
      if (mem_err) err_cnt++;
      if (alu_op != f_alu) alu_unstable = 1'b1;
      l_reg_we = reg_we; l_flag_we = flag_we; l_w_ctl = w_ctl;
      l_pc_load = pc_load; l_pc_target = pc_target; l_bus_c = bus_c_sel;
    end else if (in_instr) begin
      in_instr = 1'b0;
      if (sb.size() == 0) begin
        check("sb_pop_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        $display("txn @%0d alu=%h hold=%0d rd=%0d wr=%0d reg_we=%0b flag_we=%b w_ctl=%b pc_load=%0b pc_target=%h err_at_end=%0b",
                 cyc, f_alu, hold_cnt, rd_cnt, wr_cnt, l_reg_we, l_flag_we, l_w_ctl,
                 l_pc_load, l_pc_target, mem_err);
        check("exec_alu", f_alu, e.alu);
        check("exec_bus_a", f_bus_a, e.bus_a);
        check("alu_stable", alu_unstable, 0);
        check("hold_cycles", hold_cnt, e.hold);
        check("rd_cycles", rd_cnt, e.rd_cycles);
        check("wr_cycles", wr_cnt, e.wr_cycles);
        check("mem_addr", f_maddr, e.mem_addr);
        check("strobe_cycles", strobe_cnt, e.strobe_cycles);
        check("exec_err_cycles", err_cnt, e.err_cycles);
        check("wb_reg_we", l_reg_we, e.reg_we);
        check("wb_flag_we", l_flag_we, e.flag_we);
        check("wb_w_ctl", l_w_ctl, e.w_ctl);
        check("wb_pc_load", l_pc_load, e.pc_load);
        check("wb_pc_target", l_pc_target, e.pc_target);
        check("wb_bus_c", l_bus_c, e.bus_c);
        check("timeout_err", mem_err, e.tmo);
      end
    end else begin
      check("idle_outputs", {alu_op, reg_we, w_ctl, flag_we, pc_load, mem_rd, mem_wr, mem_err}, 0);
    end
  endtask

  // One falling edge: observe, then act as ROM and data memory
  task automatic tick();
    prog_t p;
    @(negedge clk);
    cyc++;
    monitor();
    if (!HOLD) begin
      if (prog.size() != 0) begin
        p = prog.pop_front();
        micro_instruction = p.w;
        DATA_ADDR = p.a;
        cur_rdy = p.rdy;
        if (p.w[32:29] != ALU_NOP) sb.push_back(mk_exp(p, cyc));
      end else begin
        micro_instruction = NOP_WORD;
        DATA_ADDR = '0;
      end
    end
    if (mem_rd || mem_wr) begin
      mcnt++;
      mem_ready = (mcnt == cur_rdy);
    end else begin
      mcnt = 0;
      mem_ready = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((prog.size() != 0 || sb.size() != 0 || HOLD) && n < 300) begin
      tick();
      n++;
    end
    check("drain_timeout", (n >= 300), 0);
  endtask

  initial begin
    int n;
    mcnt = 0; cur_rdy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // ADW, NOP, read (ready in 3rd MEM cycle), write timeout, JUMP,
    // zero-wait read, illegal MR+MW, reg write suppressed by Bus_C=none
    prog.push_back('{mk(4'b0101, 2'b01, 1'b1, 1'b0, 1'b0, 6'd2, 6'b000011, 7'b0111101, 5'b00100), 11'h011, 0});
    prog.push_back('{NOP_WORD, 11'h000, 0});
    prog.push_back('{mk(4'b0010, 2'b00, 1'b0, 1'b1, 1'b0, 6'd1, 6'b000101, 7'b0001010, 5'b00001), 11'h155, 3});
    prog.push_back('{mk(4'b0110, 2'b10, 1'b0, 1'b0, 1'b1, 6'd4, 6'b000111, 7'b1111111, 5'b00010), 11'h2AA, 0});
    prog.push_back('{mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, BUS_NONE, BUS_NONE, 7'b1000000, 5'b00000), 11'h3A0, 0});
    prog.push_back('{mk(4'b0011, 2'b11, 1'b1, 1'b1, 1'b0, 6'd5, 6'b001000, 7'b0000001, 5'b11111), 11'h7FF, 1});
    prog.push_back('{mk(4'b1000, 2'b00, 1'b0, 1'b1, 1'b1, 6'd6, 6'b000110, 7'b0001100, 5'b01010), 11'h0F0, 2});
    prog.push_back('{mk(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 6'd7, BUS_NONE, 7'b0001011, 5'b00011), 11'h001, 0});
    drain();
    repeat (3) tick();

    // Reset during the second MEM cycle of a read that never completes
    prog.push_back('{mk(4'b0100, 2'b00, 1'b0, 1'b1, 1'b0, 6'd1, 6'b000010, 7'b0001001, 5'b00001), 11'h123, 0});
    n = 0;
    while (!(in_instr && rd_cnt == 2) && n < 20) begin
      tick();
      n++;
    end
    check("reach_mem2", rd_cnt, 2);
    check("mem_rd_before_rst", mem_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_rd_drop", mem_rd, 0);
    check("async_hold_drop", HOLD, 0);
    micro_instruction = NOP_WORD;
    DATA_ADDR = '0;
    mem_ready = 1'b0;
    mcnt = 0;
    in_instr = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values();
    repeat (2) tick();
    prog.push_back('{mk(4'b0101, 2'b01, 1'b1, 1'b0, 1'b0, 6'd2, 6'b000011, 7'b0111101, 5'b00100), 11'h011, 0});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
